countdown_timer_6bit: RTL and testbench
=======================================

Name: countdown_timer_6bit

Overview:
- Loadable 6-bit down counter with terminal-count detection and optional auto-reload.
- It is the decrementing counterpart of the team's free-running up counters. It is used as a programmable interval/one-shot timer beside them.
- The count register is built from per-bit T flip-flop cells, each fed by a toggle vector derived from the next-state value.

Parameters:
- WIDTH, 6, counter width in bits; all count ports are WIDTH wide.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous active-high reset.
- en  input  1  count enable; decrement occurs only in cycles with en=1.
- load  input  1  synchronous load strobe; has priority over en.
- load_val  input  WIDTH  start/reload value, captured when load=1.
- auto_reload  input  1  1 = periodic mode, 0 = one-shot mode; sampled live every cycle.
- q  output  WIDTH  current count (registered).
- running  output  1  high while the state is RUN.
- done  output  1  high while the state is DONE.
- tc_pulse  output  1  one-cycle registered pulse, asserted in the same cycle q first becomes 0.

Behaviour:
- Reset value of all state and outputs, asserted asynchronously and taking effect immediately, mid-operation included:
  - q=0, reload_reg=0, state=IDLE.
  - running=0, done=0, tc_pulse=0.
- States:
  - IDLE: after reset; q holds.
  - RUN: counting.
  - DONE: one-shot expired; q holds 0.
- Load, in any state, when load=1:
  - q<=load_val and reload_reg<=load_val.
  - tc_pulse<=0.
  - Next state is RUN if load_val!=0, otherwise DONE.
  - A load with value 0 never asserts tc_pulse.
  - en is ignored in that cycle.
- RUN, en=1, load=0:
  - q>1: q<=q-1.
  - q==1: q<=0 and tc_pulse<=1. State stays RUN if auto_reload=1, otherwise goes to DONE.
  - q==0 (only reachable in periodic mode): q<=reload_reg, tc_pulse<=0, state stays RUN. If auto_reload=0 at this point, state goes to DONE and q stays 0.
- RUN, en=0: q and state hold; tc_pulse<=0.
- IDLE and DONE without load: q holds; en is ignored; tc_pulse<=0.
- Periodic period with reload value N: sequence N, N-1, …, 1, 0, N, … gives one tc_pulse every N+1 enabled cycles. Disabled cycles stretch the period and never drop or duplicate a pulse.
- Arithmetic:
  - Modulo 2^WIDTH, but q never underflows below 0 in any state.
  - load_val = 2^WIDTH-1 (63) is legal and gives period 64.
- Datapath:
  - next_q is computed combinationally.
  - Each bit's T input = q[i] XOR next_q[i].
  - Every register is an async-clear flop on reset; there are no latches.
- Outputs running and done are decoded directly from the state register (glitch-free). tc_pulse is its own flop.
- Latency:
  - load to new q visible: 1 cycle.
  - en to decrement visible: 1 cycle.
- Simultaneous load and q==1 with en=1: load wins; no tc_pulse.
- auto_reload changing mid-count affects only the next zero-crossing decision.

Decomposition:
- Shared package:
  - State encoding constants (IDLE=2'b00, RUN=2'b01, DONE=2'b10).
  - Default WIDTH.
  - Terminal-count value constant (0).
- One sub-module, t_ff_cell:
  - Ports: q, t, clk, reset.
  - Toggles on the rising edge when t=1; asynchronously cleared by reset.
  - Instantiated WIDTH times.
- FSM and next-state logic stay in the top module.

Test Plan:
- Reset mid-count: load 20, count 5 cycles (q=15), assert reset between edges -> q=0, state IDLE, running=0, done=0 immediately, without waiting for an edge.
- One-shot: load 3, auto_reload=0, en=1 -> q = 3,2,1,0 on successive edges. tc_pulse=1 only in the cycle q=0. done=1 thereafter; q stays 0 for 10 more cycles.
- Periodic with gaps: load 2, auto_reload=1, en toggled 1,0,1,1,0,1,1 -> q = 2,1,1,0,2,2,1,0. Exactly two tc_pulses, each 1 cycle wide, aligned with q=0.
- Load priority and zero load:
  - At q==1 with en=1, assert load with load_val=7 -> q=7, no tc_pulse, running=1.
  - Then load 0 -> q=0, done=1, tc_pulse=0.
- Full range: load 63, auto_reload=1, en held high for 128 cycles -> tc_pulse every 64 cycles. q wraps 0→63 and never reads an out-of-range value.
- Mode switch: periodic with load 4; deassert auto_reload while q==2 -> q reaches 0 with one tc_pulse, then DONE, q holds 0.

Source files
------------

// File: rtl/countdown_timer_6bit_pkg.sv
// rtl/countdown_timer_6bit_pkg.sv - shared constants and state encoding for the 6-bit countdown timer
package countdown_timer_6bit_pkg;

  localparam int WIDTH_DEFAULT = 6;
  localparam int TC_COUNT      = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/t_ff_cell.sv
// rtl/t_ff_cell.sv - single T flip-flop cell with asynchronous clear
module t_ff_cell (
  input  logic clk,
  input  logic reset,
  input  logic t,
  output logic q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end
  end

endmodule

// File: rtl/countdown_timer_6bit.sv
// rtl/countdown_timer_6bit.sv - loadable down counter with terminal-count pulse and optional auto-reload
module countdown_timer_6bit
  import countdown_timer_6bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             running,
  output logic             done,
  output logic             tc_pulse
);

  localparam logic [WIDTH-1:0] TC_VAL  = WIDTH'(TC_COUNT);
  localparam logic [WIDTH-1:0] ONE_VAL = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] toggle;

  always_comb begin
    q_d      = q;
    state_d  = state_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (load) begin
      q_d      = load_val;
      reload_d = load_val;
      state_d  = (load_val == TC_VAL) ? ST_DONE : ST_RUN;
    end else if (state_q == ST_RUN && en) begin
      if (q == ONE_VAL) begin
        q_d  = TC_VAL;
        tc_d = 1'b1;
        if (!auto_reload) begin
          state_d = ST_DONE;
        end
      end else if (q == TC_VAL) begin
        // Zero only survives a cycle in periodic mode; mode is re-checked here
        if (auto_reload) begin
          q_d = reload_q;
        end else begin
          state_d = ST_DONE;
        end
      end else begin
        q_d = q - ONE_VAL;
      end
    end
  end

  assign toggle = q ^ q_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    t_ff_cell u_cell (
      .clk   (clk),
      .reset (reset),
      .t     (toggle[i]),
      .q     (q[i])
    );
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign running  = (state_q == ST_RUN);
  assign done     = (state_q == ST_DONE);
  assign tc_pulse = tc_q;

endmodule

// File: tb/tb_countdown_timer_6bit.sv
// tb/tb_countdown_timer_6bit.sv - randomized and directed self-checking bench for countdown_timer_6bit
module tb_countdown_timer_6bit;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       load = 1'b0;
  logic [5:0] load_val = '0;
  logic       auto_reload = 1'b0;
  logic [5:0] q;
  logic       running, done, tc_pulse;

  int vec_cnt = 0;
  int miss_cnt = 0;

  int m_q = 0;
  int m_rel = 0;
  int m_st = M_IDLE;
  int m_tc = 0;

  always #5 clk = ~clk;

  countdown_timer_6bit #(.WIDTH(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .load        (load),
    .load_val    (load_val),
    .auto_reload (auto_reload),
    .q           (q),
    .running     (running),
    .done        (done),
    .tc_pulse    (tc_pulse)
  );

  task automatic chk(input string name, input int act, input int exp);
    vec_cnt++;
    if (act != exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q = 0; m_rel = 0; m_st = M_IDLE; m_tc = 0;
  endtask

  task automatic model_step(input bit e, input bit l, input int lv, input bit ar);
    if (l) begin
      m_q = lv; m_rel = lv; m_tc = 0;
      m_st = (lv == 0) ? M_DONE : M_RUN;
    end else if (m_st == M_RUN && e) begin
      if (m_q == 0) begin
        m_tc = 0;
        if (ar) m_q = m_rel;
        else m_st = M_DONE;
      end else begin
        m_q = m_q - 1;
        m_tc = (m_q == 0);
        if (m_q == 0 && !ar) m_st = M_DONE;
      end
    end else begin
      m_tc = 0;
    end
  endtask

  task automatic compare_all();
    chk("q", int'(q), m_q);
    chk("running", int'(running), int'(m_st == M_RUN));
    chk("done", int'(done), int'(m_st == M_DONE));
    chk("tc_pulse", int'(tc_pulse), m_tc);
  endtask

  // Inputs change just after the falling edge; outputs are compared at the next falling edge.
  task automatic step(input bit e, input bit l, input int lv, input bit ar);
    en = e; load = l; load_val = 6'(lv); auto_reload = ar;
    @(posedge clk);
    model_step(e, l, lv, ar);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    compare_all();
  endtask

  initial begin
    int tc_seen;
    int exp_q[$];
    int exp_tc[$];
    int ens[$];

    @(negedge clk);
    model_reset();
    compare_all();
    chk("reset_q_lit", int'(q), 0);
    reset = 1'b0;

    // Reset mid-count: load 20, five enabled cycles, then reset between edges
    step(0, 1, 20, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    chk("premid_q_lit", int'(q), 15);
    #2 reset = 1'b1;
    #1;
    model_reset();
    chk("async_q_lit", int'(q), 0);
    chk("async_running", int'(running), 0);
    chk("async_done", int'(done), 0);
    chk("async_tc", int'(tc_pulse), 0);
    @(negedge clk);
    reset = 1'b0;
    compare_all();

    // One-shot from 3
    exp_q = '{3, 2, 1, 0};
    exp_tc = '{0, 0, 0, 1};
    step(0, 1, 3, 0);
    chk("os_q0_lit", int'(q), exp_q[0]);
    chk("os_tc0_lit", int'(tc_pulse), exp_tc[0]);
    for (int i = 1; i < 4; i++) begin
      step(1, 0, 0, 0);
      chk("os_q_lit", int'(q), exp_q[i]);
      chk("os_tc_lit", int'(tc_pulse), exp_tc[i]);
    end
    for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
    chk("os_done_lit", int'(done), 1);
    chk("os_hold_lit", int'(q), 0);

    // Periodic reload 2 with enable gaps
    ens = '{1, 0, 1, 1, 0, 1, 1};
    exp_q = '{1, 1, 0, 2, 2, 1, 0};
    exp_tc = '{0, 0, 1, 0, 0, 0, 1};
    step(0, 1, 2, 1);
    chk("per_q0_lit", int'(q), 2);
    tc_seen = 0;
    for (int i = 0; i < 7; i++) begin
      step(ens[i][0], 0, 0, 1);
      chk("per_q_lit", int'(q), exp_q[i]);
      chk("per_tc_lit", int'(tc_pulse), exp_tc[i]);
      tc_seen += int'(tc_pulse);
    end
    chk("per_tc_count", tc_seen, 2);

    // Load beats terminal count; then a zero load goes straight to done
    step(0, 1, 2, 1);
    step(1, 0, 0, 1);
    chk("pri_pre_q_lit", int'(q), 1);
    step(1, 1, 7, 1);
    chk("pri_q_lit", int'(q), 7);
    chk("pri_tc_lit", int'(tc_pulse), 0);
    chk("pri_run_lit", int'(running), 1);
    step(1, 1, 0, 1);
    chk("zero_q_lit", int'(q), 0);
    chk("zero_done_lit", int'(done), 1);
    chk("zero_tc_lit", int'(tc_pulse), 0);

    // Full range: reload 63 gives a pulse every 64 enabled cycles
    step(0, 1, 63, 1);
    tc_seen = 0;
    for (int k = 1; k <= 128; k++) begin
      step(1, 0, 0, 1);
      tc_seen += int'(tc_pulse);
      if (k == 63) chk("full_zero_lit", int'(q), 0);
      if (k == 64) chk("full_wrap_lit", int'(q), 63);
    end
    chk("full_tc_count", tc_seen, 2);

    // Switch from periodic to one-shot while counting
    step(0, 1, 4, 1);
    step(1, 0, 0, 1);
    step(1, 0, 0, 1);
    chk("ms_q2_lit", int'(q), 2);
    tc_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, 0, 0, 0);
      tc_seen += int'(tc_pulse);
    end
    chk("ms_tc_count", tc_seen, 1);
    chk("ms_done_lit", int'(done), 1);
    chk("ms_q_lit", int'(q), 0);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      bit r_e, r_l, r_ar;
      int r_v;
      r_e = ($urandom_range(3) != 0);
      r_l = ($urandom_range(15) == 0);
      case ($urandom_range(3))
        0: r_v = $urandom_range(3);
        1: r_v = 63;
        default: r_v = $urandom_range(63);
      endcase
      r_ar = ($urandom_range(7) != 0);
      if ($urandom_range(499) == 0) begin
        do_reset();
      end else begin
        step(r_e, r_l, r_v, r_ar);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
